// File: rtl/wb_arb_n_pkg.sv
// Shared definitions for the N-channel ibus arbiter: FSM encoding, index/counter widths,
// default timeout read data and the round-robin pointer helper.
package wb_arb_n_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    localparam int          ARB_IDX_W   = 3;
    localparam int          ARB_CNT_W   = 16;
    localparam logic [31:0] ARB_ERR_RDT = 32'hFFFF_FFFF;

    // Next index modulo n; n need not be a power of two.
    function automatic logic [ARB_IDX_W-1:0] wrap_inc(input logic [ARB_IDX_W-1:0] v, input int n);
        return (int'(v) >= n - 1) ? '0 : v + 3'd1;
    endfunction

endpackage

// File: rtl/wb_arb_n_rr_pick.sv
// Combinational requester picker: first set request at or after start, wrapping modulo N.
// With rr_en low the search always starts at 0, giving lowest-index-wins priority.
module rr_pick
    import wb_arb_n_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]           req,
    input  logic [ARB_IDX_W-1:0]   start,
    input  logic                   rr_en,
    output logic                   valid,
    output logic [ARB_IDX_W-1:0]   idx
);

    logic [ARB_IDX_W-1:0] start_eff;
    logic                 hi_valid;
    logic [ARB_IDX_W-1:0] hi_idx;
    logic                 lo_valid;
    logic [ARB_IDX_W-1:0] lo_idx;

    // Descending scan so the lowest index in each half is the one left standing; requests
    // at or above start outrank the wrapped ones below it.
    // NOTE: every signal assigned here gets a default first, otherwise a latch is inferred.
    always_comb begin
        start_eff = rr_en ? start : '0;
        hi_valid  = 1'b0;
        hi_idx    = '0;
        lo_valid  = 1'b0;
        lo_idx    = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                if (i >= int'(start_eff)) begin
                    hi_valid = 1'b1;
                    hi_idx   = 3'(i);
                end else begin
                    lo_valid = 1'b1;
                    lo_idx   = 3'(i);
                end
            end
        end
    end

    assign valid = hi_valid | lo_valid;
    assign idx   = hi_valid ? hi_idx : lo_idx;

endmodule

// File: rtl/wb_arb_n.sv
// N-channel ibus arbiter: shares one cyc/adr/ack/rdt slave between requesters, holds the
// grant until ack or abort, and forces an error ack when the slave stalls past TIMEOUT.
module wb_arb_n
    import wb_arb_n_pkg::*;
#(
    parameter int             N           = 4,
    parameter int             AW          = 32,
    parameter int             DW          = 32,
    parameter int             ROUND_ROBIN = 1,
    parameter int             TIMEOUT     = 0,
    parameter logic [DW-1:0]  ERR_RDT     = DW'(ARB_ERR_RDT)
) (
    input  logic                  wb_clk,
    input  logic                  wb_rst,
    input  logic [N-1:0]          m_cyc,
    input  logic [N*AW-1:0]       m_adr,
    output logic [N-1:0]          m_ack,
    output logic [N*DW-1:0]       m_rdt,
    output logic                  x_cyc,
    output logic [AW-1:0]         x_adr,
    input  logic                  x_ack,
    input  logic [DW-1:0]         x_rdt,
    output logic [ARB_IDX_W-1:0]  grant,
    output logic                  busy,
    output logic                  timeout
);

    arb_state_e            state_q;
    logic [ARB_IDX_W-1:0]  grant_q;
    logic [ARB_IDX_W-1:0]  ptr_q;
    logic [ARB_CNT_W-1:0]  cnt_q;
    logic                  timeout_q;

    logic [ARB_IDX_W-1:0]  start_d;
    logic                  pick_valid;
    logic [ARB_IDX_W-1:0]  pick_idx;
    logic                  sel_cyc;
    logic [AW-1:0]         sel_adr;
    logic                  busy_w;
    logic                  live;
    logic                  to_hit;
    logic                  slave_ack;
    logic                  to_ack;
    logic                  ack_any;
    logic [DW-1:0]         ack_data;

    assign start_d = wrap_inc(ptr_q, N);

    rr_pick #(.N(N)) u_pick (
        .req   (m_cyc),
        .start (start_d),
        .rr_en (ROUND_ROBIN != 0),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_comb begin
        sel_cyc = 1'b0;
        sel_adr = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_q == 3'(i)) begin
                sel_cyc = m_cyc[i];
                sel_adr = m_adr[i*AW +: AW];
            end
        end
    end

    // A dropped cyc on the granted channel aborts: no ack, real or forced, reaches it.
    assign busy_w    = (state_q == ARB_BUSY);
    assign live      = busy_w & sel_cyc;
    assign to_hit    = (TIMEOUT != 0) && (cnt_q == 16'(TIMEOUT - 1));
    assign slave_ack = live & x_ack;
    assign to_ack    = live & to_hit & ~x_ack;
    assign ack_any   = slave_ack | to_ack;
    assign ack_data  = to_ack ? ERR_RDT : x_rdt;

    assign x_cyc = live & ~to_ack;
    assign x_adr = x_cyc ? sel_adr : '0;

    always_comb begin
        m_ack = '0;
        m_rdt = '0;
        for (int i = 0; i < N; i++) begin
            if (ack_any && grant_q == 3'(i)) begin
                m_ack[i]           = 1'b1;
                m_rdt[i*DW +: DW]  = ack_data;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state_q   <= ARB_IDLE;
            grant_q   <= '0;
            ptr_q     <= 3'(N - 1);
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (pick_valid) begin
                        state_q <= ARB_BUSY;
                        grant_q <= pick_idx;
                        ptr_q   <= pick_idx;
                        cnt_q   <= '0;
                    end
                end
                ARB_BUSY: begin
                    cnt_q <= cnt_q + 16'd1;
                    if (to_ack) begin
                        timeout_q <= 1'b1;
                    end
                    if (!sel_cyc || x_ack || to_hit) begin
                        state_q <= ARB_IDLE;
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

    assign grant   = grant_q;
    assign busy    = busy_w;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_wb_arb_n.sv
// Directed bench for wb_arb_n: fixed-priority table, abort, timeout, reset, and
// round-robin sequences on N=4 and N=3 instances.
module tb_wb_arb_n;

    typedef logic [127:0] w_t;

    typedef struct {
        logic [3:0]  req;
        logic [2:0]  g;
        logic [31:0] rdt;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Fixed-priority instance, TIMEOUT=8
    logic [3:0]   f_cyc;
    logic [127:0] f_adr;
    logic [3:0]   f_ack;
    logic [127:0] f_rdt;
    logic         f_xcyc;
    logic [31:0]  f_xadr;
    logic         f_xack;
    logic [31:0]  f_xrdt;
    logic [2:0]   f_grant;
    logic         f_busy;
    logic         f_to;

    // Round-robin, N=4
    logic [3:0]   r4_cyc;
    logic [127:0] r4_adr;
    logic [3:0]   r4_ack;
    logic [127:0] r4_rdt;
    logic         r4_xcyc;
    logic [31:0]  r4_xadr;
    logic         r4_xack;
    logic [31:0]  r4_xrdt;
    logic [2:0]   r4_grant;
    logic         r4_busy;
    logic         r4_to;

    // Round-robin, N=3
    logic [2:0]   r3_cyc;
    logic [95:0]  r3_adr;
    logic [2:0]   r3_ack;
    logic [95:0]  r3_rdt;
    logic         r3_xcyc;
    logic [31:0]  r3_xadr;
    logic         r3_xack;
    logic [31:0]  r3_xrdt;
    logic [2:0]   r3_grant;
    logic         r3_busy;
    logic         r3_to;

    wb_arb_n #(.N(4), .AW(32), .DW(32), .ROUND_ROBIN(0), .TIMEOUT(8)) u_fix (
        .wb_clk(clk), .wb_rst(rst), .m_cyc(f_cyc), .m_adr(f_adr), .m_ack(f_ack), .m_rdt(f_rdt),
        .x_cyc(f_xcyc), .x_adr(f_xadr), .x_ack(f_xack), .x_rdt(f_xrdt),
        .grant(f_grant), .busy(f_busy), .timeout(f_to)
    );

    wb_arb_n #(.N(4), .AW(32), .DW(32), .ROUND_ROBIN(1), .TIMEOUT(0)) u_rr4 (
        .wb_clk(clk), .wb_rst(rst), .m_cyc(r4_cyc), .m_adr(r4_adr), .m_ack(r4_ack), .m_rdt(r4_rdt),
        .x_cyc(r4_xcyc), .x_adr(r4_xadr), .x_ack(r4_xack), .x_rdt(r4_xrdt),
        .grant(r4_grant), .busy(r4_busy), .timeout(r4_to)
    );

    wb_arb_n #(.N(3), .AW(32), .DW(32), .ROUND_ROBIN(1), .TIMEOUT(0)) u_rr3 (
        .wb_clk(clk), .wb_rst(rst), .m_cyc(r3_cyc), .m_adr(r3_adr), .m_ack(r3_ack), .m_rdt(r3_rdt),
        .x_cyc(r3_xcyc), .x_adr(r3_xadr), .x_ack(r3_xack), .x_rdt(r3_xrdt),
        .grant(r3_grant), .busy(r3_busy), .timeout(r3_to)
    );

    function automatic logic [31:0] adr_of(input int i);
        return 32'hA000_0000 + 32'(i) * 32'h10;
    endfunction

    task automatic check(input string name, input w_t act, input w_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t vecs[6];
    int   rr4_seq[5];
    int   rr3_seq[4];
    int   acks[4];

    initial begin
        vecs[0] = '{4'b1010, 3'd1, 32'h1111_0001};
        vecs[1] = '{4'b0001, 3'd0, 32'h2222_0002};
        vecs[2] = '{4'b1000, 3'd3, 32'h3333_0003};
        vecs[3] = '{4'b1111, 3'd0, 32'h4444_0004};
        vecs[4] = '{4'b1100, 3'd2, 32'h5555_0005};
        vecs[5] = '{4'b0110, 3'd1, 32'h6666_0006};
        rr4_seq = '{0, 1, 2, 3, 0};
        rr3_seq = '{0, 2, 0, 2};
        acks    = '{0, 0, 0, 0};

        f_cyc = '0;  f_xack = 1'b0;  f_xrdt = '0;
        r4_cyc = '0; r4_xack = 1'b0; r4_xrdt = '0;
        r3_cyc = '0; r3_xack = 1'b0; r3_xrdt = '0;
        for (int i = 0; i < 4; i++) begin
            f_adr[i*32 +: 32]  = adr_of(i);
            r4_adr[i*32 +: 32] = adr_of(i + 8);
        end
        for (int i = 0; i < 3; i++) r3_adr[i*32 +: 32] = adr_of(i + 16);

        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        #1;
        check("rst_xcyc",  w_t'(f_xcyc),  w_t'(0));
        check("rst_xadr",  w_t'(f_xadr),  w_t'(0));
        check("rst_ack",   w_t'(f_ack),   w_t'(0));
        check("rst_rdt",   w_t'(f_rdt),   w_t'(0));
        check("rst_grant", w_t'(f_grant), w_t'(0));
        check("rst_busy",  w_t'(f_busy),  w_t'(0));
        check("rst_to",    w_t'(f_to),    w_t'(0));

        // Fixed-priority table: grant, slave muxing and ack/rdt routing
        for (int k = 0; k < 6; k++) begin
            tick();
            f_cyc = vecs[k].req;
            #1;
            check("tbl_idle_xcyc", w_t'(f_xcyc), w_t'(0));
            tick();
            #1;
            check("tbl_grant", w_t'(f_grant), w_t'(vecs[k].g));
            check("tbl_busy",  w_t'(f_busy),  w_t'(1));
            check("tbl_xcyc",  w_t'(f_xcyc),  w_t'(1));
            check("tbl_xadr",  w_t'(f_xadr),  w_t'(adr_of(int'(vecs[k].g))));
            check("tbl_noack", w_t'(f_ack),   w_t'(0));
            f_xack = 1'b1;
            f_xrdt = vecs[k].rdt;
            #1;
            check("tbl_ack", w_t'(f_ack), w_t'(4'b0001 << vecs[k].g));
            check("tbl_rdt", w_t'(f_rdt), w_t'(vecs[k].rdt) << (32 * int'(vecs[k].g)));
            tick();
            f_xack = 1'b0;
            f_xrdt = '0;
            f_cyc  = '0;
            #1;
            check("tbl_idle_after", w_t'(f_busy), w_t'(0));
        end

        // Abort two cycles into BUSY, then a stray late ack
        tick();
        f_cyc = 4'b0001;
        tick();
        #1;
        check("abort_xcyc1", w_t'(f_xcyc), w_t'(1));
        tick();
        f_cyc = '0;
        #1;
        check("abort_xcyc_drop", w_t'(f_xcyc), w_t'(0));
        check("abort_noack",     w_t'(f_ack),  w_t'(0));
        tick();
        f_xack = 1'b1;
        f_xrdt = 32'hDEAD_BEEF;
        #1;
        check("stray_ack",  w_t'(f_ack),  w_t'(0));
        check("stray_rdt",  w_t'(f_rdt),  w_t'(0));
        check("stray_busy", w_t'(f_busy), w_t'(0));
        tick();
        f_xack = 1'b0;

        // Timeout: slave never acks channel 2
        f_cyc  = 4'b0100;
        f_xrdt = 32'h1234_5678;
        tick();
        for (int c = 1; c <= 8; c++) begin
            #1;
            check("to_ack",  w_t'(f_ack),  w_t'((c == 8) ? 4'b0100 : 4'b0000));
            check("to_xcyc", w_t'(f_xcyc), w_t'((c == 8) ? 1'b0 : 1'b1));
            if (c == 8) begin
                check("to_rdt",      w_t'(f_rdt), w_t'(32'hFFFF_FFFF) << 64);
                check("to_pre_flag", w_t'(f_to),  w_t'(0));
            end
            tick();
        end
        f_cyc  = '0;
        f_xrdt = '0;
        #1;
        check("to_flag", w_t'(f_to),   w_t'(1));
        check("to_idle", w_t'(f_busy), w_t'(0));
        repeat (3) tick();
        #1;
        check("to_sticky", w_t'(f_to), w_t'(1));

        // Reset mid-BUSY, then a lone request from channel 2
        f_cyc = 4'b0010;
        tick();
        #1;
        check("rb_grant", w_t'(f_grant), w_t'(1));
        rst = 1'b1;
        tick();
        #1;
        check("rb_xcyc",  w_t'(f_xcyc),  w_t'(0));
        check("rb_busy",  w_t'(f_busy),  w_t'(0));
        check("rb_grant0", w_t'(f_grant), w_t'(0));
        check("rb_to",    w_t'(f_to),    w_t'(0));
        check("rb_ack",   w_t'(f_ack),   w_t'(0));
        rst   = 1'b0;
        f_cyc = 4'b0100;
        tick();
        #1;
        check("rb_regrant", w_t'(f_grant), w_t'(2));
        check("rb_rebusy",  w_t'(f_busy),  w_t'(1));
        check("rb_rexcyc",  w_t'(f_xcyc),  w_t'(1));
        f_cyc = '0;
        repeat (2) tick();

        // Round-robin N=4: all requests held, slave acks on the second BUSY cycle
        r4_cyc = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            #1;
            check("rr4_grant", w_t'(r4_grant), w_t'(rr4_seq[k]));
            check("rr4_busy",  w_t'(r4_busy),  w_t'(1));
            tick();
            r4_xack = 1'b1;
            r4_xrdt = 32'hC0DE_0000 + 32'(k);
            #1;
            check("rr4_ack", w_t'(r4_ack), w_t'(4'b0001 << rr4_seq[k]));
            check("rr4_rdt", w_t'(r4_rdt), w_t'(32'hC0DE_0000 + 32'(k)) << (32 * rr4_seq[k]));
            for (int i = 0; i < 4; i++) if (r4_ack[i]) acks[i]++;
            if (k == 3) begin
                for (int i = 0; i < 4; i++) check("rr4_round_acks", w_t'(acks[i]), w_t'(1));
            end
            tick();
            r4_xack = 1'b0;
            r4_xrdt = '0;
            #1;
            check("rr4_idle", w_t'(r4_busy), w_t'(0));
        end
        r4_cyc = '0;
        repeat (2) tick();

        // Round-robin N=3: channels 0 and 2 held, grants must alternate
        r3_cyc = 3'b101;
        for (int k = 0; k < 4; k++) begin
            tick();
            #1;
            check("rr3_grant", w_t'(r3_grant), w_t'(rr3_seq[k]));
            tick();
            r3_xack = 1'b1;
            r3_xrdt = 32'hBEE0_0000 + 32'(k);
            #1;
            check("rr3_ack", w_t'(r3_ack), w_t'(3'b001 << rr3_seq[k]));
            tick();
            r3_xack = 1'b0;
            r3_xrdt = '0;
        end
        r3_cyc = '0;
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
